imem_loader: RTL and testbench

- Write-side counterpart to instruction fetch. Receives a program as a little-endian byte stream over a valid/ready handshake.
- Assembles the bytes into 32-bit words and writes them sequentially into instruction memory through its write port.
- Holds the CPU (cpuHold) until the image is fully loaded.
- Sits between the boot/debug byte source and instructionMemory's write port.

---
 rtl/imem_loader.sv | 120 ++++++++++++
 tb/tb_imem_loader.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// imem_loader: byte-stream program loader into instruction memory, holding the CPU until loaded.
// Optional IMEM_LOADER_CHECKSUM_EN adds a CHECK state verifying a 32-bit sum trailer.
module imem_loader #(
    parameter int          DEPTH_WORDS = 256,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_i,
    input  logic        byteValid_i,
    input  logic [7:0]  byteData_i,
    output logic        byteReady_o,
    output logic        memWriteEnable_o,
    output logic [31:0] memWriteAddress_o,
    output logic [31:0] memWriteData_o,
    output logic        cpuHold_o,
    output logic        done_o,
    output logic        error_o,
    output logic [31:0] wordCount_o
);
`ifdef IMEM_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {IDLE, LEN, DATA, WRITE, DONE, ERROR, CHECK} state_t;
    localparam state_t FIN = CHECK;
    logic [31:0] sum_q, sum_d;
`else
    typedef enum logic [2:0] {IDLE, LEN, DATA, WRITE, DONE, ERROR} state_t;
    localparam state_t FIN = DONE;
`endif
    state_t      state_q, state_d;
    logic [1:0]  idx_q, idx_d;
    logic [23:0] shift_q, shift_d;
    logic [31:0] len_q, len_d, addr_q, addr_d, data_q, data_d, count_q, count_d;
    logic        xfer, last;
    logic [31:0] word;
    assign xfer = byteReady_o && byteValid_i;
    assign last = xfer && idx_q == 2'd3;
    // the three earlier bytes sit in shift_q, so the current byte completes the word
    assign word = {byteData_i, shift_q};
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            shift_q <= '0;
            len_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            count_q <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            len_q   <= len_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            count_q <= count_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum_q   <= sum_d;
`endif
        end
    end
    always_comb begin
        state_d = state_q;
        idx_d   = xfer ? idx_q + 2'd1 : idx_q;
        shift_d = xfer ? {byteData_i, shift_q[23:8]} : shift_q;
        len_d   = len_q;
        addr_d  = addr_q;
        data_d  = data_q;
        count_d = count_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
        sum_d   = sum_q;
`endif
        case (state_q)
            IDLE, DONE, ERROR: if (start_i) begin
                state_d = LEN;
                idx_d   = '0;
                count_d = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                sum_d   = '0;
`endif
            end
            LEN: if (last) begin
                len_d   = word;
                state_d = word == 32'd0 ? FIN : (word > 32'(DEPTH_WORDS) ? ERROR : DATA);
            end
            DATA: if (last) begin
                state_d = WRITE;
                addr_d  = BASE_ADDR + {count_q[29:0], 2'b00};
                data_d  = word;
            end
            WRITE: begin
                count_d = count_q + 32'd1;
                state_d = count_q + 32'd1 == len_q ? FIN : DATA;
`ifdef IMEM_LOADER_CHECKSUM_EN
                sum_d   = sum_q + data_q;
`endif
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            CHECK: if (last) state_d = word == sum_q ? DONE : ERROR;
`endif
            default: ;
        endcase
    end
    always_comb begin
`ifdef IMEM_LOADER_CHECKSUM_EN
        byteReady_o = state_q == LEN || state_q == DATA || state_q == CHECK;
`else
        byteReady_o = state_q == LEN || state_q == DATA;
`endif
        memWriteEnable_o  = state_q == WRITE;
        memWriteAddress_o = addr_q;
        memWriteData_o    = data_q;
        cpuHold_o         = !(state_q == IDLE || state_q == DONE);
        done_o            = state_q == DONE;
        error_o           = state_q == ERROR;
        wordCount_o       = count_q;
    end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed vectors for imem_loader (also covers IMEM_LOADER_CHECKSUM_EN builds).
module tb_imem_loader;
    logic        clk = 1'b0, rst_n = 1'b0, start_i = 1'b0, byteValid_i = 1'b0;
    logic [7:0]  byteData_i = 8'h00;
    logic        byteReady_o, memWriteEnable_o, cpuHold_o, done_o, error_o;
    logic [31:0] memWriteAddress_o, memWriteData_o, wordCount_o;
    int          total = 0, bad = 0, wtot = 0, rdy_bad = 0, cons_bad = 0, base = 0;
    logic        prev_we = 1'b0;
    logic [31:0] img [0:511];
    logic [31:0] wa [0:2047];
    logic [31:0] wd [0:2047];

    always #5 clk = ~clk;

    imem_loader dut (
        .clk(clk), .rst_n(rst_n), .start_i(start_i), .byteValid_i(byteValid_i),
        .byteData_i(byteData_i), .byteReady_o(byteReady_o), .memWriteEnable_o(memWriteEnable_o),
        .memWriteAddress_o(memWriteAddress_o), .memWriteData_o(memWriteData_o),
        .cpuHold_o(cpuHold_o), .done_o(done_o), .error_o(error_o), .wordCount_o(wordCount_o)
    );

    // write log plus protocol watchers
    always @(negedge clk) begin
        if (memWriteEnable_o && wtot < 2048) begin
            wa[wtot] <= memWriteAddress_o;
            wd[wtot] <= memWriteData_o;
        end
        if (memWriteEnable_o) wtot <= wtot + 1;
        if (memWriteEnable_o && prev_we) cons_bad <= cons_bad + 1;
        if (memWriteEnable_o && byteReady_o) rdy_bad <= rdy_bad + 1;
        prev_we <= memWriteEnable_o;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        byteValid_i = 1'b1;
        byteData_i  = b;
        while (!byteReady_o && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("rdy_timeout", byteReady_o, 1);
        @(negedge clk);
        byteValid_i = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input bit stall, input bit is_data);
        for (int i = 0; i < 4; i++) begin
            send_byte(w[8*i +: 8]);
            if (i == 3 && is_data) check("wr_latency", memWriteEnable_o, 1);
            if (stall) @(negedge clk);
        end
    endtask

    task automatic pulse_start;
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
    endtask

    task automatic load(input logic [31:0] hdr, input int n, input bit stall);
        logic [31:0] s = 32'h0;
        send_word(hdr, stall, 0);
        for (int i = 0; i < n; i++) begin
            send_word(img[i], stall, 1);
            s = s + img[i];
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        if (hdr <= 32'd256) send_word(s, stall, 0);
`endif
    endtask

    task automatic wait_end;
        int n = 0;
        while (!(done_o || error_o) && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) check("end_timeout", done_o | error_o, 1);
    endtask

    task automatic check_zero(input string pfx);
        check({pfx, "_rdy"}, byteReady_o, 0);
        check({pfx, "_we"}, memWriteEnable_o, 0);
        check({pfx, "_addr"}, memWriteAddress_o, 0);
        check({pfx, "_data"}, memWriteData_o, 0);
        check({pfx, "_hold"}, cpuHold_o, 0);
        check({pfx, "_done"}, done_o, 0);
        check({pfx, "_err"}, error_o, 0);
        check({pfx, "_wc"}, wordCount_o, 0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check_zero("rst");
        rst_n = 1'b1;
        @(negedge clk);
        // asynchronous reset in the middle of the third word
        img[0] = 32'h1122_3344;
        img[1] = 32'h5566_7788;
        pulse_start;
        send_word(32'd4, 0, 0);
        send_word(img[0], 0, 1);
        send_word(img[1], 0, 1);
        send_byte(8'h99);
        check("pre_arst_wc", wordCount_o, 2);
        #2 rst_n = 1'b0;
        #1 check_zero("arst");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        pulse_start;
        check("start_hold", cpuHold_o, 1);
        check("start_rdy", byteReady_o, 1);
        // basic load, no backpressure
        img[0] = 32'h0000_0013;
        img[1] = 32'h00A0_0093;
        base = wtot;
        load(32'd2, 2, 0);
        wait_end;
        check("basic_nwr", wtot - base, 2);
        check("basic_a0", wa[base], 32'h0);
        check("basic_d0", wd[base], 32'h0000_0013);
        check("basic_a1", wa[base+1], 32'h4);
        check("basic_d1", wd[base+1], 32'h00A0_0093);
        check("basic_done", done_o, 1);
        check("basic_hold", cpuHold_o, 0);
        check("basic_wc", wordCount_o, 2);
        check("basic_err", error_o, 0);
        check("basic_addr_hold", memWriteAddress_o, 32'h4);
        check("basic_rdy", byteReady_o, 0);
        // same image with byteValid toggling
        pulse_start;
        base = wtot;
        load(32'd2, 2, 1);
        wait_end;
        check("stall_nwr", wtot - base, 2);
        check("stall_a0", wa[base], 32'h0);
        check("stall_d0", wd[base], 32'h0000_0013);
        check("stall_a1", wa[base+1], 32'h4);
        check("stall_d1", wd[base+1], 32'h00A0_0093);
        check("stall_done", done_o, 1);
        check("rdy_in_write", rdy_bad, 0);
        check("we_back2back", cons_bad, 0);
        // empty image
        pulse_start;
        base = wtot;
        load(32'd0, 0, 0);
        wait_end;
        check("l0_nwr", wtot - base, 0);
        check("l0_done", done_o, 1);
        check("l0_wc", wordCount_o, 0);
        check("l0_hold", cpuHold_o, 0);
        // full-depth image
        for (int i = 0; i < 256; i++) img[i] = 32'h1000_0000 + 32'(i) * 3;
        pulse_start;
        base = wtot;
        load(32'd256, 256, 0);
        wait_end;
        check("full_nwr", wtot - base, 256);
        check("full_a100", wa[base+100], 32'h190);
        check("full_alast", wa[base+255], 32'h3FC);
        check("full_dlast", wd[base+255], 32'h1000_02FD);
        check("full_wc", wordCount_o, 256);
        check("full_done", done_o, 1);
        // oversize image
        pulse_start;
        base = wtot;
        load(32'd257, 0, 0);
        wait_end;
        check("big_err", error_o, 1);
        check("big_hold", cpuHold_o, 1);
        check("big_done", done_o, 0);
        check("big_nwr", wtot - base, 0);
        check("big_rdy", byteReady_o, 0);
        // restart from ERROR, with a start pulse landing mid-word
        pulse_start;
        check("rs_err_clr", error_o, 0);
        check("rs_hold", cpuHold_o, 1);
        base = wtot;
        send_word(32'd1, 0, 0);
        send_byte(8'hEF);
        send_byte(8'hBE);
        pulse_start;
        send_byte(8'hAD);
        send_byte(8'hDE);
        check("ign_latency", memWriteEnable_o, 1);
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_word(32'hDEAD_BEEF, 0, 0);
`endif
        wait_end;
        check("ign_done", done_o, 1);
        check("ign_wc", wordCount_o, 1);
        check("ign_nwr", wtot - base, 1);
        check("ign_a0", wa[base], 32'h0);
        check("ign_d0", wd[base], 32'hDEAD_BEEF);
        // restart from DONE overwrites from the base address
        pulse_start;
        check("rd_done_clr", done_o, 0);
        check("rd_err_clr", error_o, 0);
        check("rd_wc_clr", wordCount_o, 0);
        check("rd_hold", cpuHold_o, 1);
        img[0] = 32'hCAFE_F00D;
        base = wtot;
        load(32'd1, 1, 0);
        wait_end;
        check("rd_a0", wa[base], 32'h0);
        check("rd_d0", wd[base], 32'hCAFE_F00D);
        check("rd_wc", wordCount_o, 1);
        check("rd_done", done_o, 1);
`ifdef IMEM_LOADER_CHECKSUM_EN
        pulse_start;
        send_word(32'd2, 0, 0);
        send_word(32'h1, 0, 1);
        send_word(32'h2, 0, 1);
        send_word(32'h3, 0, 0);
        wait_end;
        check("ck_ok_done", done_o, 1);
        check("ck_ok_hold", cpuHold_o, 0);
        pulse_start;
        send_word(32'd2, 0, 0);
        send_word(32'h1, 0, 1);
        send_word(32'h2, 0, 1);
        send_word(32'h4, 0, 0);
        wait_end;
        check("ck_bad_err", error_o, 1);
        check("ck_bad_done", done_o, 0);
        check("ck_bad_hold", cpuHold_o, 1);
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
